ce_gen_bank: RTL



---
 rtl/ce_gen_pkg.sv | 28 ++
 rtl/ce_gen_channel.sv | 98 +++++++++
 rtl/ce_gen_bank.sv | 33 +++
 3 files changed

// File: rtl/ce_gen_pkg.sv
// Shared types and helpers for the clock-enable generator bank.
package ce_gen_pkg;

    // Counter width the config struct is built for; the bank's CNT_W must match.
    localparam int CE_CNT_W = 8;

    localparam logic MODE_INT  = 1'b0;
    localparam logic MODE_FRAC = 1'b1;

    // One channel's configuration: mode, numerator, denominator/divisor.
    typedef struct packed {
        logic                frac;
        logic [CE_CNT_W-1:0] num;
        logic [CE_CNT_W-1:0] den;
    } ce_cfg_t;

    // Effective denominator: a zero divisor behaves as divide-by-one.
    function automatic logic [CE_CNT_W-1:0] deff(input logic [CE_CNT_W-1:0] den);
        logic [CE_CNT_W-1:0] one_v;
        one_v = {{(CE_CNT_W-1){1'b0}}, 1'b1};
        if (den == {CE_CNT_W{1'b0}}) begin
            return one_v;
        end else begin
            return den;
        end
    endfunction

endpackage

// File: rtl/ce_gen_channel.sv
// One clock-enable channel: integer divider or N/D phase accumulator, with
// config changes deferred to a period boundary so the output never glitches.
module ce_gen_channel
    import ce_gen_pkg::*;
#(
    parameter int CNT_W = CE_CNT_W
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             resync,
    input  logic             cfg_frac,
    input  logic [CNT_W-1:0] cfg_num,
    input  logic [CNT_W-1:0] cfg_den,
    output logic             ce,
    output logic             cfg_ack
);

    ce_cfg_t          cfg_in_s;
    ce_cfg_t          cfg_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W:0]   acc_r;
    logic             ce_r;
    logic             ack_r;

    logic [CNT_W-1:0] deff_s;
    logic [CNT_W-1:0] neff_s;
    logic [CNT_W:0]   sum_s;
    logic             last_s;
    logic             boundary_s;
    logic             ce_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W:0]   acc_nxt_s;
    logic             changed_s;

    assign cfg_in_s = '{frac: cfg_frac, num: cfg_num, den: cfg_den};

    // Next-state of the divider/accumulator and detection of the period boundary.
    always_comb begin
        deff_s     = deff(cfg_r.den);
        neff_s     = (cfg_r.num < deff_s) ? cfg_r.num : deff_s;
        sum_s      = acc_r + {1'b0, neff_s};
        last_s     = (cnt_r == (deff_s - {{(CNT_W-1){1'b0}}, 1'b1}));
        changed_s  = (cfg_in_s != cfg_r);
        boundary_s = 1'b0;
        ce_nxt_s   = 1'b0;
        cnt_nxt_s  = cnt_r;
        acc_nxt_s  = acc_r;
        case (cfg_r.frac)
            MODE_INT: begin
                boundary_s = last_s;
                ce_nxt_s   = last_s;
                cnt_nxt_s  = last_s ? {CNT_W{1'b0}} : (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1});
            end
            MODE_FRAC: begin
                if (neff_s == {CNT_W{1'b0}}) begin
                    // No pulses; count a Deff-cycle window so a new config can still land.
                    boundary_s = last_s;
                    ce_nxt_s   = 1'b0;
                    cnt_nxt_s  = last_s ? {CNT_W{1'b0}} : (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1});
                end else begin
                    ce_nxt_s   = (sum_s >= {1'b0, deff_s});
                    boundary_s = ce_nxt_s;
                    acc_nxt_s  = ce_nxt_s ? (sum_s - {1'b0, deff_s}) : sum_s;
                end
            end
            default: begin
                boundary_s = 1'b0;
                ce_nxt_s   = 1'b0;
            end
        endcase
    end

    // Registered state: reset/resync restart, boundary-aligned config adoption.
    always_ff @(posedge clk) begin
        if (!n_reset || resync) begin
            cfg_r <= cfg_in_s;
            cnt_r <= {CNT_W{1'b0}};
            acc_r <= {(CNT_W+1){1'b0}};
            ce_r  <= 1'b0;
            ack_r <= 1'b0;
        end else if (boundary_s && changed_s) begin
            cfg_r <= cfg_in_s;
            cnt_r <= {CNT_W{1'b0}};
            acc_r <= {(CNT_W+1){1'b0}};
            ce_r  <= ce_nxt_s;
            ack_r <= 1'b1;
        end else begin
            cnt_r <= cnt_nxt_s;
            acc_r <= acc_nxt_s;
            ce_r  <= ce_nxt_s;
            ack_r <= 1'b0;
        end
    end

    assign ce      = ce_r;
    assign cfg_ack = ack_r;

endmodule

// File: rtl/ce_gen_bank.sv
// Bank of independent clock-enable channels sharing clock, reset and resync.
module ce_gen_bank
    import ce_gen_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = CE_CNT_W
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic [NUM_CH-1:0]       cfg_frac,
    input  logic [NUM_CH*CNT_W-1:0] cfg_num,
    input  logic [NUM_CH*CNT_W-1:0] cfg_den,
    input  logic                    resync,
    output logic [NUM_CH-1:0]       ce,
    output logic [NUM_CH-1:0]       cfg_ack
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ce_gen_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clk),
            .n_reset  (n_reset),
            .resync   (resync),
            .cfg_frac (cfg_frac[i]),
            .cfg_num  (cfg_num[i*CNT_W +: CNT_W]),
            .cfg_den  (cfg_den[i*CNT_W +: CNT_W]),
            .ce       (ce[i]),
            .cfg_ack  (cfg_ack[i])
        );
    end

endmodule
